// File: rtl/stage_mem.sv
// Memory-access stage: drives the data-memory request/ack bus for loads and
// stores, stalls the front of the pipeline while a transaction is open.
module stage_mem (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_i_valid,
   input  logic        mem_i_dm2rf,
   input  logic        mem_i_hilowe,
   input  logic        mem_i_rfwe,
   input  logic [4:0]  mem_i_rfwa,
   input  logic [63:0] mem_i_mulres,
   input  logic [31:0] mem_i_alures,
   input  logic [31:0] mem_i_dmdin,
   input  logic [4:0]  mem_i_memop,
   output logic        dm_req,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        stall_req,
   output logic        mem_o_valid,
   output logic        mem_o_rfwe,
   output logic        mem_o_hilowe,
   output logic [4:0]  mem_o_rfwa,
   output logic [63:0] mem_o_mulres,
   output logic [31:0] mem_o_wbdata,
   output logic        mem_o_adel,
   output logic        mem_o_ades,
   output logic [31:0] mem_o_badvaddr
);

   // state | meaning
   // IDLE  | no transaction open; pass-through or issue a new request
   // BUSY  | request outstanding, waiting for dm_ack
   // DONE  | data captured in ld_q; present the instruction for one cycle
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [31:0] ld_q, ld_d;

   logic        op_load, op_store, op_uns, is_mem, aligned, access, misal, show;
   logic [1:0]  op_size;
   logic [3:0]  be_c;
   logic [31:0] wdata_c, ld_shift, ld_ext;

   always_comb begin
      op_load  = mem_i_memop[4];
      op_store = mem_i_memop[3];
      op_size  = mem_i_memop[2:1];
      op_uns   = mem_i_memop[0];
      is_mem   = mem_i_valid & (op_load | op_store);
      case (op_size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~mem_i_alures[0];
         default: aligned = (mem_i_alures[1:0] == 2'b00);
      endcase
      access = is_mem & aligned;
      misal  = is_mem & ~aligned;

      case (op_size)
         2'b00: begin
            be_c    = 4'b0001 << mem_i_alures[1:0];
            wdata_c = {4{mem_i_dmdin[7:0]}};
         end
         2'b01: begin
            be_c    = mem_i_alures[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{mem_i_dmdin[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = mem_i_dmdin;
         end
      endcase

      // Little-endian lane select; for word accesses the shift is zero.
      ld_shift = ld_q >> {mem_i_alures[1:0], 3'b000};
      case (op_size)
         2'b00:   ld_ext = op_uns ? {24'h0, ld_shift[7:0]}
                                  : {{24{ld_shift[7]}}, ld_shift[7:0]};
         2'b01:   ld_ext = op_uns ? {16'h0, ld_shift[15:0]}
                                  : {{16{ld_shift[15]}}, ld_shift[15:0]};
         default: ld_ext = ld_shift;
      endcase

      state_d = state_q;
      ld_d    = ld_q;
      case (state_q)
         IDLE: if (access) begin
            if (dm_ack) begin
               ld_d    = dm_rdata;
               state_d = DONE;
            end else begin
               state_d = BUSY;
            end
         end
         BUSY: if (!access) begin
            state_d = IDLE;
         end else if (dm_ack) begin
            ld_d    = dm_rdata;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      dm_req    = access & (state_q != DONE);
      stall_req = dm_req;
      dm_we     = dm_req & op_store;
      dm_be     = dm_req ? be_c : 4'b0000;
      dm_addr   = dm_req ? {mem_i_alures[31:2], 2'b00} : 32'h0;
      dm_wdata  = dm_req ? wdata_c : 32'h0;

      // Exactly one visible cycle per instruction: memory ops only in DONE.
      show           = mem_i_valid & ~(access & (state_q != DONE));
      mem_o_valid    = show;
      mem_o_rfwe     = show & mem_i_rfwe & ~misal;
      mem_o_hilowe   = show & mem_i_hilowe & ~misal;
      mem_o_rfwa     = show ? mem_i_rfwa : 5'd0;
      mem_o_mulres   = show ? mem_i_mulres : 64'h0;
      mem_o_wbdata   = show ? ((access & mem_i_dm2rf) ? ld_ext : mem_i_alures) : 32'h0;
      mem_o_adel     = show & misal & op_load;
      mem_o_ades     = show & misal & op_store & ~op_load;
      mem_o_badvaddr = (show & misal) ? mem_i_alures : 32'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ld_q    <= 32'h0;
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: load results go through a scoreboard
// queue filled at issue and drained when the stage presents its DONE cycle.
module tb_stage_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_i_valid, mem_i_dm2rf, mem_i_hilowe, mem_i_rfwe;
   logic [4:0]  mem_i_rfwa;
   logic [63:0] mem_i_mulres;
   logic [31:0] mem_i_alures, mem_i_dmdin;
   logic [4:0]  mem_i_memop;
   logic        dm_req, dm_we, dm_ack;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        stall_req, mem_o_valid, mem_o_rfwe, mem_o_hilowe;
   logic [4:0]  mem_o_rfwa;
   logic [63:0] mem_o_mulres;
   logic [31:0] mem_o_wbdata, mem_o_badvaddr;
   logic        mem_o_adel, mem_o_ades;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   stage_mem dut (
      .clk(clk), .rst(rst),
      .mem_i_valid(mem_i_valid), .mem_i_dm2rf(mem_i_dm2rf),
      .mem_i_hilowe(mem_i_hilowe), .mem_i_rfwe(mem_i_rfwe),
      .mem_i_rfwa(mem_i_rfwa), .mem_i_mulres(mem_i_mulres),
      .mem_i_alures(mem_i_alures), .mem_i_dmdin(mem_i_dmdin),
      .mem_i_memop(mem_i_memop),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .stall_req(stall_req), .mem_o_valid(mem_o_valid), .mem_o_rfwe(mem_o_rfwe),
      .mem_o_hilowe(mem_o_hilowe), .mem_o_rfwa(mem_o_rfwa),
      .mem_o_mulres(mem_o_mulres), .mem_o_wbdata(mem_o_wbdata),
      .mem_o_adel(mem_o_adel), .mem_o_ades(mem_o_ades),
      .mem_o_badvaddr(mem_o_badvaddr)
   );

   task automatic clear_inputs();
      mem_i_valid = 0; mem_i_dm2rf = 0; mem_i_hilowe = 0; mem_i_rfwe = 0;
      mem_i_rfwa = 0; mem_i_mulres = 0; mem_i_alures = 0; mem_i_dmdin = 0;
      mem_i_memop = 0; dm_ack = 0; dm_rdata = 0;
   endtask

   // Runs one memory instruction; ack arrives in cycle index 'waits'.
   task automatic do_mem(input logic ld, input logic st, input logic [1:0] sz,
                         input logic un, input logic [31:0] addr, input logic [31:0] din,
                         input logic [31:0] rd, input int waits,
                         output int stalls, output logic [3:0] be_o, output logic we_o,
                         output logic [31:0] addr_o, output logic [31:0] wdata_o,
                         output logic [31:0] wb_o, output logic bad_stall, output logic timeout);
      mem_i_valid = 1; mem_i_memop = {ld, st, sz, un};
      mem_i_alures = addr; mem_i_dmdin = din;
      mem_i_dm2rf = ld; mem_i_rfwe = ld; mem_i_rfwa = 5'd9;
      mem_i_hilowe = 0; mem_i_mulres = 0;
      stalls = 0; be_o = 0; we_o = 0; addr_o = 0; wdata_o = 0; wb_o = 0;
      bad_stall = 0; timeout = 1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         dm_ack   = (cyc == waits);
         dm_rdata = (cyc == waits) ? rd : 32'h0;
         @(negedge clk);
         if (stall_req) begin
            if (stalls == 0) begin
               be_o = dm_be; we_o = dm_we; addr_o = dm_addr; wdata_o = dm_wdata;
            end
            stalls++;
            if (mem_o_valid || !dm_req) bad_stall = 1;
         end else if (mem_o_valid) begin
            wb_o = mem_o_wbdata;
            timeout = 0;
         end
         @(posedge clk); #1;
         if (!timeout) break;
      end
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      #1;
      n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_dm_req got %b want 0", dm_req); end
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_req); end
      n_checks++; if (mem_o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", mem_o_valid); end
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_passthrough();
      mem_i_valid = 1; mem_i_alures = 32'h0000_1234; mem_i_rfwe = 1; mem_i_rfwa = 5'd8;
      @(negedge clk);
      n_checks++; if (mem_o_wbdata !== 32'h1234) begin n_fail++; $display("FAIL add_wbdata got %h want 00001234", mem_o_wbdata); end
      n_checks++; if (mem_o_rfwe !== 1'b1 || mem_o_rfwa !== 5'd8 || mem_o_valid !== 1'b1) begin
         n_fail++; $display("FAIL add_ctrl got rfwe=%b rfwa=%0d valid=%b want 1/8/1", mem_o_rfwe, mem_o_rfwa, mem_o_valid); end
      n_checks++; if (stall_req !== 1'b0 || dm_req !== 1'b0) begin
         n_fail++; $display("FAIL add_nostall got stall=%b req=%b want 0/0", stall_req, dm_req); end
      @(posedge clk); #1;
      clear_inputs();
      mem_i_valid = 1; mem_i_mulres = 64'h1_0000_0002; mem_i_hilowe = 1; mem_i_alures = 32'h55;
      @(negedge clk);
      n_checks++; if (mem_o_mulres !== 64'h1_0000_0002 || mem_o_hilowe !== 1'b1) begin
         n_fail++; $display("FAIL mult_pass got mulres=%h hilowe=%b want 100000002/1", mem_o_mulres, mem_o_hilowe); end
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL mult_nostall got %b want 0", stall_req); end
      @(posedge clk); #1;
      clear_inputs();
      mem_i_alures = 32'hFFFF_FFFF; mem_i_rfwe = 1; mem_i_rfwa = 5'd3; mem_i_mulres = 64'h7; mem_i_memop = 5'b10100;
      @(negedge clk);
      n_checks++; if ({mem_o_valid, mem_o_rfwe, mem_o_rfwa, mem_o_wbdata, mem_o_mulres, dm_req, stall_req} !== '0) begin
         n_fail++; $display("FAIL invalid_zero got valid=%b rfwe=%b wb=%h req=%b want all 0", mem_o_valid, mem_o_rfwe, mem_o_wbdata, dm_req); end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_loads();
      int st; logic [3:0] be; logic we, bad, to; logic [31:0] ad, wd, wb, exp;
      // LB 0x103, two wait cycles
      sb_q.push_back(32'hFFFF_FF80);
      do_mem(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF_0000, 2, st, be, we, ad, wd, wb, bad, to);
      exp = sb_q.pop_front();
      n_checks++; if (to || wb !== exp) begin n_fail++; $display("FAIL lb_data got %h timeout=%b want %h", wb, to, exp); end
      n_checks++; if (st != 3) begin n_fail++; $display("FAIL lb_stalls got %0d want 3", st); end
      n_checks++; if (be !== 4'b1000 || we !== 1'b0 || ad !== 32'h100) begin
         n_fail++; $display("FAIL lb_bus got be=%b we=%b addr=%h want 1000/0/00000100", be, we, ad); end
      n_checks++; if (bad) begin n_fail++; $display("FAIL lb_stall_cycle got valid-or-noreq during stall want clean"); end
      // LBU same access
      sb_q.push_back(32'h0000_0080);
      do_mem(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF_0000, 2, st, be, we, ad, wd, wb, bad, to);
      exp = sb_q.pop_front();
      n_checks++; if (to || wb !== exp) begin n_fail++; $display("FAIL lbu_data got %h timeout=%b want %h", wb, to, exp); end
      // LH / LHU upper half
      sb_q.push_back(32'hFFFF_8001);
      do_mem(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h8001_1234, 0, st, be, we, ad, wd, wb, bad, to);
      exp = sb_q.pop_front();
      n_checks++; if (to || wb !== exp || st != 1) begin n_fail++; $display("FAIL lh_data got %h stalls=%0d want %h/1", wb, st, exp); end
      sb_q.push_back(32'h0000_1234);
      do_mem(1, 0, 2'b01, 1, 32'h100, 32'h0, 32'h8001_1234, 0, st, be, we, ad, wd, wb, bad, to);
      exp = sb_q.pop_front();
      n_checks++; if (to || wb !== exp || be !== 4'b0011) begin n_fail++; $display("FAIL lhu_data got %h be=%b want %h/0011", wb, be, exp); end
      // LW with one wait cycle
      sb_q.push_back(32'hDEAD_BEEF);
      do_mem(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, st, be, we, ad, wd, wb, bad, to);
      exp = sb_q.pop_front();
      n_checks++; if (to || wb !== exp || st != 2) begin n_fail++; $display("FAIL lw_data got %h stalls=%0d want %h/2", wb, st, exp); end
   endtask

   task automatic test_stores();
      int st; logic [3:0] be; logic we, bad, to; logic [31:0] ad, wd, wb, exp;
      sb_q.push_back(32'h0000_0202);
      do_mem(0, 1, 2'b01, 0, 32'h202, 32'hAAAA_BEEF, 32'h0, 0, st, be, we, ad, wd, wb, bad, to);
      exp = sb_q.pop_front();
      n_checks++; if (we !== 1'b1 || be !== 4'b1100 || wd !== 32'hBEEF_BEEF || ad !== 32'h200) begin
         n_fail++; $display("FAIL sh_bus got we=%b be=%b wdata=%h addr=%h want 1/1100/beefbeef/00000200", we, be, wd, ad); end
      n_checks++; if (st != 1 || to || wb !== exp) begin n_fail++; $display("FAIL sh_done got stalls=%0d wb=%h want 1/%h", st, wb, exp); end
      sb_q.push_back(32'h0000_0301);
      do_mem(0, 1, 2'b00, 0, 32'h301, 32'h1234_5678, 32'h0, 1, st, be, we, ad, wd, wb, bad, to);
      exp = sb_q.pop_front();
      n_checks++; if (be !== 4'b0010 || wd !== 32'h7878_7878 || st != 2 || wb !== exp) begin
         n_fail++; $display("FAIL sb_bus got be=%b wdata=%h stalls=%0d wb=%h want 0010/78787878/2/%h", be, wd, st, wb, exp); end
      sb_q.push_back(32'h0000_0400);
      do_mem(0, 1, 2'b10, 0, 32'h400, 32'hCAFE_F00D, 32'h0, 0, st, be, we, ad, wd, wb, bad, to);
      exp = sb_q.pop_front();
      n_checks++; if (be !== 4'b1111 || wd !== 32'hCAFE_F00D || wb !== exp) begin
         n_fail++; $display("FAIL sw_bus got be=%b wdata=%h wb=%h want 1111/cafef00d/%h", be, wd, wb, exp); end
   endtask

   task automatic test_misaligned();
      mem_i_valid = 1; mem_i_memop = 5'b10100; mem_i_alures = 32'h105;
      mem_i_rfwe = 1; mem_i_dm2rf = 1; mem_i_rfwa = 5'd4;
      @(negedge clk);
      n_checks++; if (mem_o_adel !== 1'b1 || mem_o_ades !== 1'b0 || mem_o_badvaddr !== 32'h105) begin
         n_fail++; $display("FAIL lw_adel got adel=%b ades=%b bad=%h want 1/0/00000105", mem_o_adel, mem_o_ades, mem_o_badvaddr); end
      n_checks++; if (mem_o_rfwe !== 1'b0 || dm_req !== 1'b0 || stall_req !== 1'b0) begin
         n_fail++; $display("FAIL lw_adel_ctrl got rfwe=%b req=%b stall=%b want 0/0/0", mem_o_rfwe, dm_req, stall_req); end
      @(posedge clk); #1;
      clear_inputs();
      mem_i_valid = 1; mem_i_memop = 5'b01010; mem_i_alures = 32'h201; mem_i_hilowe = 1;
      @(negedge clk);
      n_checks++; if (mem_o_ades !== 1'b1 || mem_o_adel !== 1'b0 || mem_o_badvaddr !== 32'h201 || mem_o_hilowe !== 1'b0 || dm_req !== 1'b0) begin
         n_fail++; $display("FAIL sh_ades got ades=%b adel=%b bad=%h hilowe=%b req=%b want 1/0/00000201/0/0",
                            mem_o_ades, mem_o_adel, mem_o_badvaddr, mem_o_hilowe, dm_req); end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_reset_busy();
      int st; logic [3:0] be; logic we, bad, to; logic [31:0] ad, wd, wb, exp;
      mem_i_valid = 1; mem_i_memop = 5'b10100; mem_i_alures = 32'h100; mem_i_dm2rf = 1; mem_i_rfwe = 1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (stall_req !== 1'b1 || dm_req !== 1'b1) begin
         n_fail++; $display("FAIL busy_hold got stall=%b req=%b want 1/1", stall_req, dm_req); end
      #2;
      rst = 1; mem_i_valid = 0;
      #1;
      n_checks++; if (dm_req !== 1'b0 || stall_req !== 1'b0) begin
         n_fail++; $display("FAIL busy_reset got req=%b stall=%b want 0/0", dm_req, stall_req); end
      n_checks++; if (dut.ld_q !== 32'h0 || dut.state_q !== 2'd0) begin
         n_fail++; $display("FAIL busy_reset_state got ld_q=%h state=%0d want 0/0", dut.ld_q, dut.state_q); end
      @(posedge clk); #1;
      rst = 0;
      clear_inputs();
      @(posedge clk); #1;
      sb_q.push_back(32'h0000_00AB);
      do_mem(1, 0, 2'b00, 1, 32'h500, 32'h0, 32'h0000_00AB, 0, st, be, we, ad, wd, wb, bad, to);
      exp = sb_q.pop_front();
      n_checks++; if (to || st != 1 || wb !== exp) begin
         n_fail++; $display("FAIL after_reset got stalls=%0d wb=%h timeout=%b want 1/%h/0", st, wb, to, exp); end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_loads();
      test_stores();
      test_misaligned();
      test_reset_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access stage of the five-stage MIPS pipeline. It sits directly downstream of the execute stage, behind the `regs_exemem` pipeline register, and drives the data-memory request/acknowledge bus. Every load and store takes a multi-cycle transaction, and the stage stalls the front of the pipeline while one is outstanding. Non-memory instructions pass through with zero added latency; their results, including the 64-bit multiply result, reach `regs_memwb` unchanged.

## Interface
Parameters:
- none; widths come from `mip_cpu_pkg` (`word_t`=32, `double_word_t`=64, `reg_enum`=5 bits).
- `memop_struct` = {`load`, `store`, `size[1:0]` (00 byte, 01 half, 10 word), `uns`}.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_i_valid`  in  1  `regs_exemem` holds a live instruction.
- `mem_i_dm2rf`, `mem_i_hilowe`, `mem_i_rfwe`  in  1 each  control passed from execute.
- `mem_i_rfwa`  in  5  destination register.
- `mem_i_mulres`  in  64  multiply result.
- `mem_i_alures`  in  32  ALU result; this is the effective address for memory ops.
- `mem_i_dmdin`  in  32  store data.
- `mem_i_memop`  in  `memop_struct`  memory operation.
- `dm_req`  out  1  data-memory request.
- `dm_we`  out  1  write request.
- `dm_be`  out  4  byte enables.
- `dm_addr`  out  32  word address, `{alures[31:2],2'b00}`.
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_ack`  in  1  transaction complete.
- `dm_rdata`  in  32  read word; valid when `dm_ack`=1.
- `stall_req`  out  1  hold PC, `regs_ifid`, `regs_idexe` and `regs_exemem`.
- `mem_o_valid`, `mem_o_rfwe`, `mem_o_hilowe`  out  1 each.
- `mem_o_rfwa`  out  5.
- `mem_o_mulres`  out  64.
- `mem_o_wbdata`  out  32.
- `mem_o_adel`, `mem_o_ades`  out  1 each  misaligned load or store.
- `mem_o_badvaddr`  out  32  faulting address.

## Operation
FSM with states IDLE, BUSY, DONE. The load buffer `ld_q` is 32 bits.
- An access is a `mem_i_valid` cycle with `load` or `store` set and an aligned address.
- Alignment: byte is always aligned; half requires `addr[0]`=0; word requires `addr[1:0]`=0.
- **IDLE, no access:** outputs are a combinational pass-through. `mem_o_wbdata`=`alures`, `stall_req`=0.
- **IDLE, access present:** `dm_req`=1 and `stall_req`=1, both combinational.
  - On `dm_ack`=1 in the same cycle: capture `ld_q`, go to DONE.
  - Otherwise: go to BUSY.
- **BUSY:** `dm_req` and `stall_req` stay at 1, and `dm_*` outputs stay stable. On `dm_ack`: capture `ld_q`, go to DONE.
- **DONE:** `dm_req`=0 and `stall_req`=0. Outputs carry the instruction with `wbdata` = extracted `ld_q` when `dm2rf`=1. The pipeline advances at the next edge, and the FSM returns to IDLE.
- **Stores:**
  - `dm_we`=1.
  - Byte: `be` = 1<<`addr[1:0]`, `wdata` = {4{`dmdin[7:0]`}}.
  - Half: `be` = `addr[1]` ? 1100 : 0011, `wdata` = {2{`dmdin[15:0]`}}.
  - Word: `be` = 1111, `wdata` = `dmdin`.
- **Loads:**
  - `dm_we`=0 and `be` is as for stores.
  - Extraction is little-endian: `rdata >> (8*addr[1:0])`, truncated to the access size.
  - The result is zero-extended when `uns`=1 and sign-extended otherwise.
- **Misaligned access:**
  - No request is issued and no stall is raised.
  - `mem_o_adel` (load) or `mem_o_ades` (store) = 1.
  - `mem_o_badvaddr` = `alures`.
  - `mem_o_rfwe`=0 and `mem_o_hilowe`=0.
- **`mem_i_valid`=0:** all `mem_o_*` outputs are 0, `dm_req`=0 and `stall_req`=0.
- **BUSY/DONE outputs:** `mem_o_valid`=0 in IDLE-with-access and in BUSY; it is 1 only in DONE for a memory op. Control outputs are masked the same way, so write-back sees exactly one valid cycle per instruction.

## Timing
- **Reset:** state=IDLE and `ld_q`=0, applied asynchronously. `dm_req`, `stall_req` and `mem_o_valid` drop to 0 immediately, given `mem_i_valid`=0 from the reset upstream register.
- **Reset mid-transaction:** abandons the request. The memory must treat `dm_req` falling as an abort; it does not need to return `dm_ack`.
- **Non-memory ops:** 0 cycles added.
- **Memory op with ack in the request cycle:** 1 stall cycle, then DONE.
- **Memory op with ack after N wait cycles:** 1+N stall cycles.
- **Upstream:** `regs_exemem` must hold its contents while `stall_req`=1. Inputs are therefore stable from the IDLE request cycle through DONE.
- **`dm_ack` outside IDLE-with-access or BUSY:** ignored.

## Test plan
- ADD result 0x0000_1234 with `rfwe`=1 and `rfwa`=8 -> same cycle `mem_o_wbdata`=0x1234, `mem_o_rfwe`=1, `stall_req`=0, `dm_req`=0.
- LB at addr 0x103 with `dm_rdata`=0x80FF_0000 and ack after 2 wait cycles -> `stall_req` high 3 cycles; in DONE `wbdata`=0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- SH at addr 0x202 with `dmdin`=0xAAAA_BEEF and ack in the request cycle -> `dm_we`=1, `dm_be`=1100, `dm_wdata`=0xBEEF_BEEF, `dm_addr`=0x200, 1 stall cycle.
- LW at addr 0x105 -> `mem_o_adel`=1, `badvaddr`=0x105, `rfwe`=0, `dm_req`=0, `stall_req`=0.
- MULT with `mulres`=0x1_0000_0002 and `hilowe`=1 -> passed through unchanged with no stall.
- LW issued, `rst` pulsed while in BUSY -> `dm_req`=0 and `stall_req`=0 immediately; after release the FSM is in IDLE and `ld_q`=0.
